// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
//   Uses the Tuse/Tnew model to decide when the D-stage instruction must be
//   held (PC and D register disabled, bubble into E), picks forwarding
//   sources for D- and E-stage operands (M has priority over W), and owns
//   the multiply/divide busy counter.
//
//   Optional feature (macro HAZ_PERF_CNT_EN): when defined, stall_cycles
//   counts clock edges on which the pipeline was stalled. When undefined,
//   stall_cycles is tied to zero.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   rs_D, rt_D                  D-stage source register addresses
//   tuse_rs_D, tuse_rt_D        cycles until each D source is consumed
//   md_use_D                    D instruction touches the mult/div unit
//   rs_E, rt_E                  E-stage source register addresses
//   wreg_{E,M,W}, regwrite_*    destination register and write enable
//   tnew_E, tnew_M              cycles until the stage's result exists
//   md_start_E, md_is_div_E     mult/div launch in E and its kind
//   en_F, en_D, flush_E         stall / bubble controls
//   fwd_{rs,rt}_{D,E}           0 = no forward, 1 = from M, 2 = from W
//   md_busy                     mult/div unit busy
//   stall_cycles                stall performance counter
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs_D,
   input  logic [1:0]  tuse_rt_D,
   input  logic        md_use_D,
   input  logic [4:0]  rs_E,
   input  logic [4:0]  rt_E,
   input  logic [4:0]  wreg_E,
   input  logic [4:0]  wreg_M,
   input  logic [4:0]  wreg_W,
   input  logic        regwrite_E,
   input  logic        regwrite_M,
   input  logic        regwrite_W,
   input  logic [1:0]  tnew_E,
   input  logic [1:0]  tnew_M,
   input  logic        md_start_E,
   input  logic        md_is_div_E,
   output logic        en_F,
   output logic        en_D,
   output logic        flush_E,
   output logic [1:0]  fwd_rs_D,
   output logic [1:0]  fwd_rt_D,
   output logic [1:0]  fwd_rs_E,
   output logic [1:0]  fwd_rt_E,
   output logic        md_busy,
   output logic [31:0] stall_cycles
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   localparam logic [1:0] FWD_NONE = 2'd0;
   localparam logic [1:0] FWD_M    = 2'd1;
   localparam logic [1:0] FWD_W    = 2'd2;

   // A producer matches a source only if it really writes that register;
   // $0 is hard-wired and never matches.
   function automatic logic reg_match(input logic [4:0] src,
                                      input logic       we,
                                      input logic [4:0] dst);
      return (src != 5'd0) && we && (dst == src);
   endfunction

   // Producer's value arrives later than the consumer needs it.
   function automatic logic late(input logic [4:0] src,
                                 input logic [1:0] tuse,
                                 input logic       we,
                                 input logic [4:0] dst,
                                 input logic [1:0] tnew);
      return reg_match(src, we, dst) && (tnew > tuse);
   endfunction

   // M wins over W only when M's result is already computed.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       we_m,
                                          input logic [4:0] dst_m,
                                          input logic [1:0] tnew_m,
                                          input logic       we_w,
                                          input logic [4:0] dst_w);
      if (reg_match(src, we_m, dst_m) && (tnew_m == 2'd0))
         return FWD_M;
      else if (reg_match(src, we_w, dst_w))
         return FWD_W;
      else
         return FWD_NONE;
   endfunction

   logic             data_stall;
   logic             md_stall;
   logic             stall;
   logic [CNT_W-1:0] md_cnt;

   // W is never a stall source: its tnew is always 0.
   assign data_stall = late(rs_D, tuse_rs_D, regwrite_E, wreg_E, tnew_E)
                     | late(rs_D, tuse_rs_D, regwrite_M, wreg_M, tnew_M)
                     | late(rt_D, tuse_rt_D, regwrite_E, wreg_E, tnew_E)
                     | late(rt_D, tuse_rt_D, regwrite_M, wreg_M, tnew_M);

   // md_start_E covers the launch cycle, before the counter is loaded.
   assign md_stall = md_use_D & (md_start_E | md_busy);
   assign stall    = data_stall | md_stall;

   assign en_F    = ~stall;
   assign en_D    = ~stall;
   assign flush_E = stall;

   assign fwd_rs_D = fwd_sel(rs_D, regwrite_M, wreg_M, tnew_M, regwrite_W, wreg_W);
   assign fwd_rt_D = fwd_sel(rt_D, regwrite_M, wreg_M, tnew_M, regwrite_W, wreg_W);
   assign fwd_rs_E = fwd_sel(rs_E, regwrite_M, wreg_M, tnew_M, regwrite_W, wreg_W);
   assign fwd_rt_E = fwd_sel(rt_E, regwrite_M, wreg_M, tnew_M, regwrite_W, wreg_W);

   // Busy counter: a new start always reloads (last start wins); otherwise
   // count down to zero and hold there.
   always_ff @(posedge clk) begin
      if (rst)
         md_cnt <= '0;
      else if (md_start_E)
         md_cnt <= md_is_div_E ? DIV_LOAD : MULT_LOAD;
      else if (md_cnt != '0)
         md_cnt <= md_cnt - 1'b1;
   end

   assign md_busy = (md_cnt != '0);

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt;

   // Free-running wrap at 2^32 is intended.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall)
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  rs_D, rt_D, rs_E, rt_E, wreg_E, wreg_M, wreg_W;
   logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
   logic        md_use_D, regwrite_E, regwrite_M, regwrite_W;
   logic        md_start_E, md_is_div_E;
   logic        en_F, en_D, flush_E, md_busy;
   logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
   logic [31:0] stall_cycles;

   int n_cmp;
   int n_bad;

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
      .md_use_D(md_use_D), .rs_E(rs_E), .rt_E(rt_E),
      .wreg_E(wreg_E), .wreg_M(wreg_M), .wreg_W(wreg_W),
      .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
      .tnew_E(tnew_E), .tnew_M(tnew_M),
      .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
      .en_F(en_F), .en_D(en_D), .flush_E(flush_E),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
      .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
      .md_busy(md_busy), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs_d, rt_d;
      logic [1:0] tu_rs, tu_rt;
      logic [4:0] rs_e, rt_e;
      logic [4:0] wr_e, wr_m, wr_w;
      logic       we_e, we_m, we_w;
      logic [1:0] tn_e, tn_m;
      logic       x_stall;
      logic [1:0] x_rs_d, x_rt_d, x_rs_e, x_rt_e;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string nm,
                               logic [4:0] rsd, logic [4:0] rtd,
                               logic [1:0] tur, logic [1:0] tut,
                               logic [4:0] rse, logic [4:0] rte,
                               logic [4:0] we_r, logic [4:0] wm_r, logic [4:0] ww_r,
                               logic ee, logic em, logic ew,
                               logic [1:0] te, logic [1:0] tm,
                               logic xs, logic [1:0] a, logic [1:0] b,
                               logic [1:0] c, logic [1:0] d);
      vec_t v;
      v.name = nm; v.rs_d = rsd; v.rt_d = rtd; v.tu_rs = tur; v.tu_rt = tut;
      v.rs_e = rse; v.rt_e = rte; v.wr_e = we_r; v.wr_m = wm_r; v.wr_w = ww_r;
      v.we_e = ee; v.we_m = em; v.we_w = ew; v.tn_e = te; v.tn_m = tm;
      v.x_stall = xs; v.x_rs_d = a; v.x_rt_d = b; v.x_rs_e = c; v.x_rt_e = d;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_stall(string nm, logic xs);
      chk({nm, ".en_F"}, 32'(en_F), 32'(!xs));
      chk({nm, ".en_D"}, 32'(en_D), 32'(!xs));
      chk({nm, ".flush_E"}, 32'(flush_E), 32'(xs));
   endtask

   task automatic clear_inputs();
      rs_D = 0; rt_D = 0; tuse_rs_D = 0; tuse_rt_D = 0; md_use_D = 0;
      rs_E = 0; rt_E = 0; wreg_E = 0; wreg_M = 0; wreg_W = 0;
      regwrite_E = 0; regwrite_M = 0; regwrite_W = 0; tnew_E = 0; tnew_M = 0;
      md_start_E = 0; md_is_div_E = 0;
   endtask

   // advance to just after the next active edge, where inputs are driven
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_perf;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clear_inputs();
      rst = 1'b1;

      //        name        rsD rtD tur tut rsE rtE wE wM wW eE eM eW tE tM  st  rsD rtD rsE rtE
      vecs.push_back(mk("lu_E",    8, 0, 1, 0, 0, 0, 8, 0, 0, 1, 0, 0, 2, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk("lu_M_br", 8, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk("lu_M_alu",8, 0, 1, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("lu_W",    8, 0, 1, 0, 0, 0, 0, 0, 8, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0));
      vecs.push_back(mk("alu_fwd", 0, 0, 0, 0, 9, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk("m_prio",  0, 0, 0, 0, 9, 0, 0, 9, 9, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk("zero_g",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk("no_we",   8, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("rt_E_st", 0, 5, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk("rt_eq",   0, 5, 0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("w_fwd_E", 0, 0, 0, 0, 7, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 2, 2));
      vecs.push_back(mk("m_nrdy",  0, 0, 0, 0, 6, 0, 0, 6, 6, 0, 1, 1, 0, 1, 0, 0, 0, 2, 0));
      vecs.push_back(mk("m_fwd_D", 4, 4, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      vecs.push_back(mk("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // reset state
      step();
      step();
      @(negedge clk);
      chk("rst.md_busy", 32'(md_busy), 32'd0);
      chk("rst.stall_cycles", stall_cycles, 32'd0);
      chk_stall("rst", 1'b0);
      step();
      rst = 1'b0;

      // combinational table
      foreach (vecs[i]) begin
         rs_D = vecs[i].rs_d; rt_D = vecs[i].rt_d;
         tuse_rs_D = vecs[i].tu_rs; tuse_rt_D = vecs[i].tu_rt;
         rs_E = vecs[i].rs_e; rt_E = vecs[i].rt_e;
         wreg_E = vecs[i].wr_e; wreg_M = vecs[i].wr_m; wreg_W = vecs[i].wr_w;
         regwrite_E = vecs[i].we_e; regwrite_M = vecs[i].we_m; regwrite_W = vecs[i].we_w;
         tnew_E = vecs[i].tn_e; tnew_M = vecs[i].tn_m;
         @(negedge clk);
         chk_stall(vecs[i].name, vecs[i].x_stall);
         chk({vecs[i].name, ".fwd_rs_D"}, 32'(fwd_rs_D), 32'(vecs[i].x_rs_d));
         chk({vecs[i].name, ".fwd_rt_D"}, 32'(fwd_rt_D), 32'(vecs[i].x_rt_d));
         chk({vecs[i].name, ".fwd_rs_E"}, 32'(fwd_rs_E), 32'(vecs[i].x_rs_e));
         chk({vecs[i].name, ".fwd_rt_E"}, 32'(fwd_rt_E), 32'(vecs[i].x_rt_e));
         chk({vecs[i].name, ".md_busy"}, 32'(md_busy), 32'd0);
         step();
      end

      // fresh reset so the perf count only sees the mult/mflo sequence
      clear_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;

      // mult then mflo: stall in start cycle + 5 busy cycles
      md_use_D = 1'b1;
      md_start_E = 1'b1;
      md_is_div_E = 1'b0;
      @(negedge clk);
      chk_stall("mul.c0", 1'b1);
      chk("mul.c0.md_busy", 32'(md_busy), 32'd0);
      step();
      md_start_E = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("mul.c%0d.md_busy", k), 32'(md_busy), 32'd1);
         chk_stall($sformatf("mul.c%0d", k), 1'b1);
         step();
      end
      @(negedge clk);
      chk("mul.c6.md_busy", 32'(md_busy), 32'd0);
      chk_stall("mul.c6", 1'b0);
`ifdef HAZ_PERF_CNT_EN
      exp_perf = 32'd6;
`else
      exp_perf = 32'd0;
`endif
      chk("mul.stall_cycles", stall_cycles, exp_perf);

      // reload: mult, then div two cycles later -> 10 busy cycles after div
      step();
      md_use_D = 1'b0;
      md_start_E = 1'b1;
      md_is_div_E = 1'b0;
      step();
      md_start_E = 1'b0;
      step();
      md_start_E = 1'b1;
      md_is_div_E = 1'b1;
      step();
      md_start_E = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1 || k == 10)
            chk($sformatf("reload.c%0d.md_busy", k), 32'(md_busy), 32'd1);
         step();
      end
      @(negedge clk);
      chk("reload.c11.md_busy", 32'(md_busy), 32'd0);

      // div with reset in busy cycle 3
      step();
      md_start_E = 1'b1;
      md_is_div_E = 1'b1;
      step();
      md_start_E = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("divrst.c3.md_busy", 32'(md_busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      md_use_D = 1'b1;
      @(negedge clk);
      chk("divrst.c4.md_busy", 32'(md_busy), 32'd0);
      chk_stall("divrst.c4", 1'b0);
      chk("divrst.stall_cycles", stall_cycles, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
